// File: rtl/counter_chk_pkg.sv
// Shared types and constants for the up/down counter monitor.
package counter_chk_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } chk_state_t;

  localparam int MODE_UP   = 1;
  localparam int MODE_DOWN = 0;

endpackage

// File: rtl/counter_chk_predict.sv
// Predicts the observed counter's current value from the previous sample,
// and flags when that step is the wrap-around edge.
module counter_chk_predict
  import counter_chk_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MODE  = MODE_DOWN
) (
  input  logic [WIDTH-1:0] ref_q,
  input  logic             ref_en,
  output logic [WIDTH-1:0] exp_q,
  output logic             is_wrap_edge
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] step_q;
  logic             at_edge;

  always_comb begin
    step_q  = ref_q;
    at_edge = 1'b0;
    if (MODE == MODE_UP) begin
      step_q  = ref_q + ONE;
      at_edge = (ref_q == ALL_ONES);
    end else begin
      step_q  = ref_q - ONE;
      at_edge = (ref_q == ZERO);
    end
    exp_q        = ref_en ? step_q : ref_q;
    is_wrap_edge = ref_en && at_edge;
  end

endmodule

// File: rtl/counter_checker.sv
// On-chip monitor for an up/down counter: predicts each sample from the
// previous one, pulses err/wrap, and keeps a sticky flag and saturating count.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MODE      = MODE_DOWN,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     exp_q,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 wrap
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  chk_state_t           state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic                 ref_en_q, ref_en_d;
  logic                 err_q, err_d;
  logic                 wrap_q, wrap_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]     pred_q;
  logic                 is_wrap_edge;
  logic                 mismatch;

  counter_chk_predict #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_predict (
    .ref_q        (ref_q),
    .ref_en       (ref_en_q),
    .exp_q        (pred_q),
    .is_wrap_edge (is_wrap_edge)
  );

  always_comb begin
    state_d  = state_q;
    ref_d    = q_in;
    ref_en_d = en;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    mismatch = 1'b0;

    if (state_q == INIT) begin
      state_d = TRACK;
    end else begin
      mismatch = (q_in != pred_q);
      err_d    = mismatch;
      wrap_d   = !mismatch && is_wrap_edge;
    end

    // A mismatch in the same cycle as clr_err still counts: it lands as 1.
    if (mismatch) begin
      sticky_d = 1'b1;
      if (clr_err)             cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= INIT;
      ref_q    <= '0;
      ref_en_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      ref_en_q <= ref_en_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign exp_q      = pred_q;
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench: one down-mode and one up-mode checker side by side,
// expected outputs queued per edge from a behavioural counter model.
module tb_counter_checker;

  localparam int W  = 6;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          en_dn, en_up, clr_dn, clr_up;
  logic [W-1:0]  q_dn, q_up;
  logic [W-1:0]  exp_dn, exp_up;
  logic          err_dn, err_up, stk_dn, stk_up, wrap_dn, wrap_up;
  logic [CW-1:0] cnt_dn, cnt_up;

  counter_checker #(.WIDTH(W), .MODE(0), .ERR_CNT_W(CW)) u_dn (
    .clk(clk), .rst(rst), .en(en_dn), .q_in(q_dn), .clr_err(clr_dn),
    .exp_q(exp_dn), .err(err_dn), .err_sticky(stk_dn), .err_cnt(cnt_dn), .wrap(wrap_dn)
  );

  counter_checker #(.WIDTH(W), .MODE(1), .ERR_CNT_W(CW)) u_up (
    .clk(clk), .rst(rst), .en(en_up), .q_in(q_up), .clr_err(clr_up),
    .exp_q(exp_up), .err(err_up), .err_sticky(stk_up), .err_cnt(cnt_up), .wrap(wrap_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          wrap;
    logic          sticky;
    logic [CW-1:0] cnt;
    logic [W-1:0]  eq;
  } obs_t;

  obs_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_seen_dn = 0;
  int err_seen_dn  = 0;

  // behavioural model state, index 0 = down instance, 1 = up instance
  logic         m_trk [2];
  logic [W-1:0] m_ref [2];
  logic         m_ren [2];
  logic         m_err [2];
  logic         m_wrap[2];
  logic         m_stk [2];
  logic [CW-1:0] m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] next_of(input int i, input logic [W-1:0] q, input logic e);
    if (!e) return q;
    return (i == 1) ? q + 6'd1 : q - 6'd1;
  endfunction

  // Drive one cycle on instance sel (0=down, 1=up); the other keeps its inputs.
  task automatic step(input int sel, input logic r, input logic e,
                      input logic [W-1:0] q, input logic c);
    obs_t o;
    obs_t g;
    rst = r;
    if (sel == 0) begin en_dn = e; q_dn = q; clr_dn = c; end
    else          begin en_up = e; q_up = q; clr_up = c; end

    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] qi;
      logic ei, ci, mis;
      qi = (i == 0) ? q_dn : q_up;
      ei = (i == 0) ? en_dn : en_up;
      ci = (i == 0) ? clr_dn : clr_up;
      if (!r) begin
        m_trk[i] = 1'b0; m_ref[i] = '0; m_ren[i] = 1'b0;
        m_err[i] = 1'b0; m_wrap[i] = 1'b0; m_stk[i] = 1'b0; m_cnt[i] = '0;
      end else if (!m_trk[i]) begin
        m_trk[i] = 1'b1; m_err[i] = 1'b0; m_wrap[i] = 1'b0;
        m_ref[i] = qi; m_ren[i] = ei;
      end else begin
        mis = (qi != next_of(i, m_ref[i], m_ren[i]));
        m_err[i]  = mis;
        m_wrap[i] = !mis && m_ren[i] &&
                    ((i == 1) ? (m_ref[i] == 6'd63 && qi == 6'd0)
                              : (m_ref[i] == 6'd0 && qi == 6'd63));
        if (mis) begin
          m_stk[i] = 1'b1;
          m_cnt[i] = ci ? 8'd1 : ((m_cnt[i] == 8'd255) ? 8'd255 : m_cnt[i] + 8'd1);
        end else if (ci) begin
          m_stk[i] = 1'b0;
          m_cnt[i] = 8'd0;
        end
        m_ref[i] = qi; m_ren[i] = ei;
      end
      o.err = m_err[i]; o.wrap = m_wrap[i]; o.sticky = m_stk[i];
      o.cnt = m_cnt[i]; o.eq = next_of(i, m_ref[i], m_ren[i]);
      sb_q.push_back(o);
    end

    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("dn_err",  32'(err_dn),  32'(g.err));
    chk("dn_wrap", 32'(wrap_dn), 32'(g.wrap));
    chk("dn_stk",  32'(stk_dn),  32'(g.sticky));
    chk("dn_cnt",  32'(cnt_dn),  32'(g.cnt));
    chk("dn_expq", 32'(exp_dn),  32'(g.eq));
    g = sb_q.pop_front();
    chk("up_err",  32'(err_up),  32'(g.err));
    chk("up_wrap", 32'(wrap_up), 32'(g.wrap));
    chk("up_stk",  32'(stk_up),  32'(g.sticky));
    chk("up_cnt",  32'(cnt_up),  32'(g.cnt));
    chk("up_expq", 32'(exp_up),  32'(g.eq));
    if (wrap_dn) wrap_seen_dn++;
    if (err_dn)  err_seen_dn++;
  endtask

  task automatic do_reset();
    en_dn = 1'b0; q_dn = '0; clr_dn = 1'b0;
    en_up = 1'b0; q_up = '0; clr_up = 1'b0;
    step(0, 1'b0, 1'b0, 6'd0, 1'b0);
    step(0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    en_dn = 1'b0; q_dn = '0; clr_dn = 1'b0;
    en_up = 1'b0; q_up = '0; clr_up = 1'b0;

    // reset state
    do_reset();
    chk("rst_cnt", 32'(cnt_dn), 0);
    chk("rst_expq", 32'(exp_up), 0);

    // down count through the wrap
    wrap_seen_dn = 0; err_seen_dn = 0;
    step(0, 1'b1, 1'b1, 6'd0, 1'b0);
    step(0, 1'b1, 1'b1, 6'd63, 1'b0);
    chk("dn_wrap_now", 32'(wrap_dn), 1);
    for (int v = 62; v >= 50; v--) step(0, 1'b1, 1'b1, 6'(v), 1'b0);
    chk("dn_wrap_once", wrap_seen_dn, 1);
    chk("dn_no_err", err_seen_dn, 0);

    // up count with a forced jump, then resync
    do_reset();
    step(1, 1'b1, 1'b1, 6'd10, 1'b0);
    step(1, 1'b1, 1'b1, 6'd11, 1'b0);
    step(1, 1'b1, 1'b1, 6'd20, 1'b0);
    chk("up_jump_err", 32'(err_up), 1);
    chk("up_jump_cnt", 32'(cnt_up), 1);
    step(1, 1'b1, 1'b1, 6'd21, 1'b0);
    chk("up_resync", 32'(err_up), 0);
    step(1, 1'b1, 1'b1, 6'd62, 1'b0);
    step(1, 1'b1, 1'b1, 6'd63, 1'b0);
    step(1, 1'b1, 1'b1, 6'd0, 1'b0);
    chk("up_wrap", 32'(wrap_up), 1);

    // disabled counter must hold
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 1'b1, 1'b0, 6'd5, 1'b0);
    step(1, 1'b1, 1'b0, 6'd6, 1'b0);
    chk("hold_err", 32'(err_up), 1);
    step(1, 1'b1, 1'b0, 6'd6, 1'b0);
    step(1, 1'b1, 1'b0, 6'd6, 1'b0);
    chk("hold_ok", 32'(err_up), 0);
    chk("hold_cnt", 32'(cnt_up), 1);

    // saturation on the down instance (sitting at q=0, en=0)
    for (int k = 0; k < 300; k++) step(0, 1'b1, 1'b0, (k % 2 == 0) ? 6'd5 : 6'd0, 1'b0);
    chk("sat_cnt", 32'(cnt_dn), 255);
    chk("sat_err", 32'(err_dn), 1);

    // clr_err racing a mismatch
    do_reset();
    step(1, 1'b1, 1'b0, 6'd0, 1'b0);
    step(1, 1'b1, 1'b0, 6'd1, 1'b0);
    step(1, 1'b1, 1'b0, 6'd2, 1'b0);
    step(1, 1'b1, 1'b0, 6'd3, 1'b0);
    chk("clr_pre", 32'(cnt_up), 3);
    step(1, 1'b1, 1'b0, 6'd4, 1'b1);
    chk("clr_race_cnt", 32'(cnt_up), 1);
    chk("clr_race_stk", 32'(stk_up), 1);
    step(1, 1'b1, 1'b0, 6'd4, 1'b1);
    chk("clr_cnt", 32'(cnt_up), 0);
    chk("clr_stk", 32'(stk_up), 0);

    // reset mid-operation
    step(1, 1'b1, 1'b0, 6'd8, 1'b0);
    step(1, 1'b1, 1'b0, 6'd9, 1'b0);
    step(1, 1'b1, 1'b0, 6'd10, 1'b0);
    step(1, 1'b1, 1'b0, 6'd11, 1'b0);
    chk("mid_pre", 32'(cnt_up), 4);
    step(1, 1'b0, 1'b1, 6'd12, 1'b0);
    chk("mid_cnt", 32'(cnt_up), 0);
    chk("mid_stk", 32'(stk_up), 0);
    step(1, 1'b1, 1'b1, 6'd37, 1'b0);
    chk("mid_first", 32'(err_up), 0);
    step(1, 1'b1, 1'b1, 6'd38, 1'b0);
    chk("mid_next", 32'(err_up), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable on-chip monitor for the up/down counter.
- Samples the counter's enable and output every clock, predicts the next count, and flags any deviation.
- Also reports correct wrap-arounds, keeps a saturating error count and a sticky error flag.
- Sits beside the counter, sharing its clock and reset, and feeds status/debug logic.

Parameters:
WIDTH, 6, bit width of the observed counter value
MODE, 0, count direction of the observed counter: 1 = up, 0 = down
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, shared with the observed counter
rst  input  1  synchronous active-low reset, shared with the observed counter
en  input  1  observed counter enable
q_in  input  WIDTH  observed counter output
clr_err  input  1  synchronous clear of err_sticky and err_cnt
exp_q  output  WIDTH  predicted value of q_in for the current cycle (valid in TRACK)
err  output  1  one-cycle pulse: mismatch detected
err_sticky  output  1  set on any mismatch, held until clr_err or reset
err_cnt  output  ERR_CNT_W  number of mismatches, saturating at all-ones
wrap  output  1  one-cycle pulse: correct wrap-around observed

Behaviour:
- Reset (rst low at a clk edge):
  - state = INIT; all outputs 0.
  - Internal ref_q = 0 and ref_en = 0.
- Counter model: q(t+1) = en(t) ? q(t) ± 1 : q(t), modulo 2^WIDTH.
  - Direction: + for MODE=1, − for MODE=0.
- exp_q is combinational from the registers:
  - ref_en ? ref_q ± 1 (wrapping, WIDTH bits) : ref_q.
- States:
  - INIT:
    - First edge after reset deasserts: capture ref_q <= q_in, ref_en <= en.
    - Go to TRACK. No check is made; err and wrap stay 0.
  - TRACK, every edge:
    - Compare q_in with exp_q.
    - ref_q <= q_in and ref_en <= en, always. This resyncs to the observed value after a mismatch, so a single glitch costs exactly one error.
  - No other states. Checking continues after errors.
- Mismatch (q_in != exp_q in TRACK):
  - err = 1 for the next cycle (registered, 1-cycle latency).
  - err_sticky <= 1.
  - err_cnt <= err_cnt + 1, saturating at 2^ERR_CNT_W − 1 (holds, never wraps).
- Wrap, flagged in TRACK when ref_en = 1, q_in == exp_q, and:
  - MODE=1: ref_q == all-ones and q_in == 0.
  - MODE=0: ref_q == 0 and q_in == all-ones.
  - Result: wrap = 1 for the next cycle.
  - Wrap and err are mutually exclusive.
- clr_err:
  - Clears err_sticky and err_cnt.
  - Does not affect state, ref_q, err or wrap.
  - If clr_err and a mismatch happen in the same cycle: err_cnt <= 1, err_sticky <= 1 (mismatch wins).
- Reset mid-operation:
  - Everything returns to INIT next edge, including err_cnt and err_sticky.
  - The first post-reset sample is never checked, because the counter's reset value is not assumed.
- en toggling: any en pattern is legal; the prediction always uses en from the previous edge.

Decomposition:
- Package counter_chk_pkg holds:
  - enum chk_state_t {INIT, TRACK}
  - localparams MODE_UP = 1, MODE_DOWN = 0
- One sub-module is natural: counter_chk_predict.
  - Purely combinational; parameters WIDTH, MODE.
  - Inputs ref_q, ref_en; outputs exp_q and is_wrap_edge.
  - The top keeps the FSM, registers, error counter and clr_err logic.

Test Plan (WIDTH=6, ERR_CNT_W=8):
- MODE=0, reset then q_in=0, en=1 and q_in stepping 0→63→62… -> wrap pulses exactly once, the cycle after q_in=63 appears; err never asserted; exp_q tracks q_in.
- MODE=1, q_in = 10, 11, then forced to 20 with en=1 -> err pulse one cycle after q_in=20, err_sticky=1, err_cnt=1; the following 21 gives no error (resync).
- en held 0 with q_in steady at 5, then q_in changes to 6 while en was 0 -> err pulse, err_cnt increments; with en=0 and steady q_in, no err.
- Inject 300 consecutive mismatches (q_in alternating 0/5, en=0) -> err_cnt saturates at 255 and holds; err pulses every cycle.
- err_cnt=3, assert clr_err in the same cycle as a mismatch -> err_cnt=1, err_sticky=1; next cycle clr_err alone -> err_cnt=0, err_sticky=0.
- Assert rst mid-count with err_cnt=4 -> next edge all outputs 0; first sample after release (any q_in, e.g. 37) raises no err.
